bs_mult: RTL and testbench

Bit-serial multiplier. It takes two operands, x and y, as LSB-first serial streams in lock-step and emits their product, truncated to WIDTH bits, as an LSB-first serial stream with one cycle of latency. Word boundaries are marked by firstbit and lastbit strobes. It is a leaf arithmetic element for the serial datapath of the accelerator.

---
 rtl/bs_mult_pkg.sv | 4 +
 rtl/bs_mult.sv | 55 +++++
 tb/tb_bs_mult.sv | 103 ++++++++++
 3 files changed

// File: rtl/bs_mult_pkg.sv
// bs_mult_pkg: shared constants for the bit-serial multiplier
package bs_mult_pkg;
  localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/bs_mult.sv
// bs_mult: LSB-first bit-serial multiplier (p = x*y mod 2^WIDTH, one cycle late); in clk, rst_n (async low), x, y, firstbit, lastbit; out p
module bs_mult
  import bs_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  input  logic firstbit,
  input  logic lastbit,
  output logic p
);
  localparam int IW = $clog2(WIDTH) + 1;
  logic             in_frame, valid, last;
  logic [IW-1:0]    i_q, ir;
  logic [WIDTH-1:0] x_q, y_q, xr, yr, yn;
  logic [WIDTH+1:0] a_q, ar, s;
  always_comb begin
    valid = firstbit | in_frame;
    xr    = firstbit ? '0 : x_q;
    yr    = firstbit ? '0 : y_q;
    ar    = firstbit ? '0 : a_q;
    ir    = firstbit ? '0 : i_q;
    yn    = yr | (WIDTH'(y) << ir);
    s     = ar + (x ? {2'b00, yn} : '0) + (y ? {2'b00, xr} : '0);
    last  = lastbit | (ir == IW'(WIDTH - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p        <= 1'b0;
      in_frame <= 1'b0;
      i_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      a_q      <= '0;
    end else begin
      p <= valid & s[0];
      if (valid && !last) begin
        in_frame <= 1'b1;
        x_q      <= xr | (WIDTH'(x) << ir);
        y_q      <= yn;
        a_q      <= s >> 1;
        i_q      <= ir + 1'b1;
      end else if (valid) begin
        in_frame <= 1'b0;
        i_q      <= '0;
        x_q      <= '0;
        y_q      <= '0;
        a_q      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bs_mult.sv
// tb_bs_mult: scoreboard bench for bs_mult with directed and random serial words
module tb_bs_mult;
  typedef struct {
    logic e;
    int   t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, x, y, firstbit, lastbit, p;
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tid = 0;
  bs_mult #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .firstbit(firstbit), .lastbit(lastbit), .p(p)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (p !== e.e) begin
        n_err++;
        $display("FAIL test %0d p: got %b expected %b", e.t, p, e.e);
      end
    end
  end
  task automatic cyc(input logic f, input logic l, input logic xb, input logic yb, input logic e);
    exp_t v;
    firstbit = f;
    lastbit  = l;
    x        = xb;
    y        = yb;
    @(posedge clk);
    v.e = e;
    v.t = tid;
    q.push_back(v);
    #1;
  endtask
  task automatic frame(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] pv,
                       input int n, input int cut);
    for (int k = 0; k < cut; k++) cyc(k == 0, k == n - 1, xv[k], yv[k], pv[k]);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] xv, yv;
    int cut;
    rst_n = 1'b0;
    {x, y, firstbit, lastbit} = '0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tid = 1;
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tid = 2;
    frame(32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000003, 32, 32);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tid = 3;
    frame(32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32, 32);
    tid = 4;
    frame(32'd3, 32'd5, 32'h0000000F, 32, 32);
    frame(32'd7, 32'd9, 32'h0000003F, 32, 32);
    tid = 5;
    frame(32'd3, 32'd7, 32'h00000015, 32, 10);
    frame(32'h00001234, 32'h00000010, 32'h00012340, 32, 32);
    tid = 6;
    frame(32'h000000AB, 32'h000000CD, 32'h000000EF, 8, 8);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tid = 7;
    frame(32'd1, 32'd1, 32'd1, 1, 1);
    frame(32'd1, 32'd0, 32'd0, 1, 1);
    frame(32'd1, 32'd1, 32'd1, 1, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 1000; w++) begin
      tid = 100 + w;
      xv  = $urandom;
      yv  = $urandom;
      if (w % 50 == 49) begin
        cut = $urandom_range(1, 31);
        frame(xv, yv, xv * yv, 32, cut);
        rst_pulse();
        repeat (3) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        frame(xv, yv, xv * yv, 32, 32);
      end
    end
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
